// File: rtl/apb_controller.sv
// APB side of the AHB-to-APB bridge. Takes the pipelined transfer
// information from the AHB slave stage and runs the two-cycle APB
// SETUP/ENABLE handshake toward up to NSEL peripherals. It also drives
// hready_out, which stalls the AHB master while a write is pending
// behind another write and while a read is in its SETUP cycle.
module apb_controller #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSEL   = 3
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              valid,
    input  logic              hwrite,
    input  logic              hwrite_reg,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [ADDR_W-1:0] haddr_0,
    input  logic [ADDR_W-1:0] haddr_1,
    input  logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hwdata_0,
    input  logic [DATA_W-1:0] hwdata_1,
    input  logic [NSEL-1:0]   temp_sel,
    input  logic [DATA_W-1:0] prdata,
    output logic [NSEL-1:0]   pselx,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              hready_out,
    output logic [DATA_W-1:0] hrdata
);

    // WRITEP / WENABLEP are the variants used while a second write
    // (or a read) is already queued behind the current APB write.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WWAIT    = 3'd1,
        ST_WRITE    = 3'd2,
        ST_WRITEP   = 3'd3,
        ST_WENABLE  = 3'd4,
        ST_WENABLEP = 3'd5,
        ST_READ     = 3'd6,
        ST_RENABLE  = 3'd7
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [NSEL-1:0]     pselx_reg;
    logic                penable_reg;
    logic                pwrite_reg;
    logic [ADDR_W-1:0]   paddr_reg;
    logic [DATA_W-1:0]   pwdata_reg;
    logic                hready_reg;

    // The two-deep write data delay is only kept for interface symmetry
    // with the slave stage; nothing in this block consumes it.
    logic unused_hwdata_1;
    assign unused_hwdata_1 = ^hwdata_1;

    // Read data is passed straight back to the AHB side without a register.
    assign hrdata = prdata;

    assign pselx      = pselx_reg;
    assign penable    = penable_reg;
    assign pwrite     = pwrite_reg;
    assign paddr      = paddr_reg;
    assign pwdata     = pwdata_reg;
    assign hready_out = hready_reg;

    // Next-state decode; the registered outputs are built from this value.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (valid && hwrite)       state_next = ST_WWAIT;
                else if (valid && !hwrite) state_next = ST_READ;
                else                       state_next = ST_IDLE;
            end
            ST_WWAIT: begin
                state_next = valid ? ST_WRITEP : ST_WRITE;
            end
            ST_WRITE: begin
                state_next = valid ? ST_WENABLEP : ST_WENABLE;
            end
            ST_WRITEP: begin
                state_next = ST_WENABLEP;
            end
            ST_WENABLEP: begin
                if (!hwrite_reg)  state_next = ST_READ;
                else if (valid)   state_next = ST_WRITEP;
                else              state_next = ST_WRITE;
            end
            ST_WENABLE, ST_RENABLE: begin
                if (valid && !hwrite)     state_next = ST_READ;
                else if (valid && hwrite) state_next = ST_WWAIT;
                else                      state_next = ST_IDLE;
            end
            ST_READ: begin
                state_next = ST_RENABLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register and registered APB/AHB outputs, set for the state being entered.
    always_ff @(posedge hclk) begin
        if (hresetn) begin
            state_reg   <= ST_IDLE;
            pselx_reg   <= '0;
            penable_reg <= 1'b0;
            pwrite_reg  <= 1'b0;
            paddr_reg   <= '0;
            pwdata_reg  <= '0;
            hready_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            case (state_next)
                ST_READ: begin
                    pselx_reg   <= temp_sel;
                    pwrite_reg  <= 1'b0;
                    penable_reg <= 1'b0;
                    hready_reg  <= 1'b0;
                    // A read queued behind a write carries its address two stages back.
                    paddr_reg   <= (state_reg == ST_WENABLEP) ? haddr_1 : haddr;
                end
                ST_WRITE, ST_WRITEP: begin
                    pselx_reg   <= temp_sel;
                    pwrite_reg  <= 1'b1;
                    penable_reg <= 1'b0;
                    hready_reg  <= (state_next == ST_WRITE);
                    if (state_reg == ST_WENABLEP) begin
                        paddr_reg  <= haddr_1;
                        pwdata_reg <= hwdata_0;
                    end else begin
                        paddr_reg  <= haddr_0;
                        pwdata_reg <= hwdata;
                    end
                end
                ST_WENABLE, ST_WENABLEP, ST_RENABLE: begin
                    penable_reg <= 1'b1;
                    hready_reg  <= 1'b1;
                end
                default: begin
                    // IDLE and WWAIT: bus quiet, address/data/direction held.
                    pselx_reg   <= '0;
                    penable_reg <= 1'b0;
                    hready_reg  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_controller.sv
// Directed bench for apb_controller. A behavioural model of the bridge
// sequencing runs alongside the DUT and a compare process checks every
// output each cycle; directed literal checks pin the model to the
// expected waveforms of each scenario.
module tb_apb_controller;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b1;
    logic        valid = 1'b0;
    logic        hwrite = 1'b0;
    logic        hwrite_reg = 1'b0;
    logic [31:0] haddr = '0;
    logic [31:0] haddr_0 = '0;
    logic [31:0] haddr_1 = '0;
    logic [31:0] hwdata = '0;
    logic [31:0] hwdata_0 = '0;
    logic [31:0] hwdata_1 = '0;
    logic [2:0]  temp_sel = '0;
    logic [31:0] prdata = '0;
    logic [2:0]  pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        hready_out;
    logic [31:0] hrdata;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit cmp_en = 1'b0;
    int acc_cnt;

    apb_controller #(.ADDR_W(32), .DATA_W(32), .NSEL(3)) dut (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .valid      (valid),
        .hwrite     (hwrite),
        .hwrite_reg (hwrite_reg),
        .haddr      (haddr),
        .haddr_0    (haddr_0),
        .haddr_1    (haddr_1),
        .hwdata     (hwdata),
        .hwdata_0   (hwdata_0),
        .hwdata_1   (hwdata_1),
        .temp_sel   (temp_sel),
        .prdata     (prdata),
        .pselx      (pselx),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .hready_out (hready_out),
        .hrdata     (hrdata)
    );

    always #5 hclk = ~hclk;

    // Upstream slave-stage delay lines.
    always @(posedge hclk) begin
        haddr_0    <= haddr;
        haddr_1    <= haddr_0;
        hwdata_0   <= hwdata;
        hwdata_1   <= hwdata_0;
        hwrite_reg <= hwrite;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Bridge phases, named after what the APB bus is doing.
    localparam int P_QUIET     = 0;  // nothing on APB, nothing queued
    localparam int P_WAIT_DATA = 1;  // write address seen, data one cycle later
    localparam int P_WR_SETUP  = 2;  // write setup, nothing queued
    localparam int P_WR_SETUPQ = 3;  // write setup, another transfer queued
    localparam int P_WR_EN     = 4;  // write enable, nothing queued
    localparam int P_WR_ENQ    = 5;  // write enable, queued transfer pending
    localparam int P_RD_SETUP  = 6;
    localparam int P_RD_EN     = 7;

    int          m_phase = P_QUIET;
    logic [2:0]  e_psel = '0;
    logic        e_pen = 1'b0;
    logic        e_pwr = 1'b0;
    logic [31:0] e_paddr = '0;
    logic [31:0] e_pwdata = '0;
    logic        e_hready = 1'b1;

    function automatic int m_after(input int ph, input logic v, input logic w, input logic wq);
        int r;
        r = P_QUIET;
        if (ph == P_WAIT_DATA) r = v ? P_WR_SETUPQ : P_WR_SETUP;
        else if (ph == P_WR_SETUP) r = v ? P_WR_ENQ : P_WR_EN;
        else if (ph == P_WR_SETUPQ) r = P_WR_ENQ;
        else if (ph == P_RD_SETUP) r = P_RD_EN;
        else if (ph == P_WR_ENQ) r = !wq ? P_RD_SETUP : (v ? P_WR_SETUPQ : P_WR_SETUP);
        else if (v) r = w ? P_WAIT_DATA : P_RD_SETUP;  // quiet or any finished access
        return r;
    endfunction

    always @(posedge hclk) begin
        if (hresetn) begin
            m_phase  <= P_QUIET;
            e_psel   <= '0;
            e_pen    <= 1'b0;
            e_pwr    <= 1'b0;
            e_paddr  <= '0;
            e_pwdata <= '0;
            e_hready <= 1'b1;
        end else begin
            m_phase <= m_after(m_phase, valid, hwrite, hwrite_reg);
            case (m_after(m_phase, valid, hwrite, hwrite_reg))
                P_RD_SETUP: begin
                    e_psel   <= temp_sel;
                    e_pen    <= 1'b0;
                    e_pwr    <= 1'b0;
                    e_hready <= 1'b0;
                    e_paddr  <= (m_phase == P_WR_ENQ) ? haddr_1 : haddr;
                end
                P_WR_SETUP, P_WR_SETUPQ: begin
                    e_psel   <= temp_sel;
                    e_pen    <= 1'b0;
                    e_pwr    <= 1'b1;
                    e_hready <= (m_after(m_phase, valid, hwrite, hwrite_reg) == P_WR_SETUP);
                    e_paddr  <= (m_phase == P_WR_ENQ) ? haddr_1 : haddr_0;
                    e_pwdata <= (m_phase == P_WR_ENQ) ? hwdata_0 : hwdata;
                end
                P_WR_EN, P_WR_ENQ, P_RD_EN: begin
                    e_pen    <= 1'b1;
                    e_hready <= 1'b1;
                end
                default: begin
                    e_psel   <= '0;
                    e_pen    <= 1'b0;
                    e_hready <= 1'b1;
                end
            endcase
        end
    end

    // ---------------- compare process ----------------
    logic [2:0]  prev_psel = '0;
    logic        prev_pen = 1'b0;
    logic        prev_pwr = 1'b0;
    logic [31:0] prev_paddr = '0;

    // Checks all outputs against the model and the APB protocol rules every cycle.
    always @(negedge hclk) begin
        if (cmp_en) begin
            chk("m_pselx", {29'd0, pselx}, {29'd0, e_psel});
            chk("m_penable", {31'd0, penable}, {31'd0, e_pen});
            chk("m_pwrite", {31'd0, pwrite}, {31'd0, e_pwr});
            chk("m_paddr", paddr, e_paddr);
            chk("m_pwdata", pwdata, e_pwdata);
            chk("m_hready", {31'd0, hready_out}, {31'd0, e_hready});
            chk("m_hrdata", hrdata, prdata);
            chk("psel_onehot0", {31'd0, $onehot0(pselx)}, 32'd1);
            if (penable)
                chk("enable_after_setup",
                    {31'd0, (!prev_pen && prev_psel == pselx && prev_paddr == paddr && prev_pwr == pwrite)},
                    32'd1);
        end
        prev_psel  <= pselx;
        prev_pen   <= penable;
        prev_pwr   <= pwrite;
        prev_paddr <= paddr;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] s);
        valid    = v;
        hwrite   = w;
        haddr    = a;
        hwdata   = d;
        temp_sel = s;
    endtask

    task automatic rand_in();
        valid    = 1'($urandom);
        hwrite   = 1'($urandom);
        haddr    = $urandom;
        hwdata   = $urandom;
        temp_sel = 3'($urandom_range(0, 7));
        prdata   = $urandom;
    endtask

    initial begin
        // 1. reset with random inputs
        hresetn = 1'b1;
        rand_in();
        tick();
        cmp_en = 1'b1;
        rand_in();
        tick();
        chk("rst_pselx", {29'd0, pselx}, 32'd0);
        chk("rst_penable", {31'd0, penable}, 32'd0);
        chk("rst_pwrite", {31'd0, pwrite}, 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_hready", {31'd0, hready_out}, 32'd1);
        hresetn = 1'b0;
        set_in(0, 0, 32'd0, 32'd0, 3'b000);
        prdata = 32'd0;
        tick();
        chk("idle_pselx", {29'd0, pselx}, 32'd0);

        // 2. single write
        set_in(1, 1, 32'h8000_0010, 32'd0, 3'b001);
        tick();
        chk("t2_wwait_psel", {29'd0, pselx}, 32'd0);
        set_in(0, 0, 32'd0, 32'hA5A5_0001, 3'b001);
        tick();
        chk("t2_write_psel", {29'd0, pselx}, 32'd1);
        chk("t2_write_paddr", paddr, 32'h8000_0010);
        chk("t2_write_pwdata", pwdata, 32'hA5A5_0001);
        chk("t2_write_pen", {31'd0, penable}, 32'd0);
        chk("t2_write_pwrite", {31'd0, pwrite}, 32'd1);
        set_in(0, 0, 32'd0, 32'd0, 3'b000);
        tick();
        chk("t2_wenable_pen", {31'd0, penable}, 32'd1);
        tick();
        chk("t2_idle_psel", {29'd0, pselx}, 32'd0);
        chk("t2_idle_paddr_hold", paddr, 32'h8000_0010);

        // 3. single read
        set_in(1, 0, 32'h8400_0020, 32'd0, 3'b010);
        prdata = 32'h1234_5678;
        tick();
        chk("t3_read_paddr", paddr, 32'h8400_0020);
        chk("t3_read_pwrite", {31'd0, pwrite}, 32'd0);
        chk("t3_read_hready", {31'd0, hready_out}, 32'd0);
        chk("t3_read_psel", {29'd0, pselx}, 32'd2);
        set_in(0, 0, 32'd0, 32'd0, 3'b000);
        tick();
        chk("t3_renable_pen", {31'd0, penable}, 32'd1);
        chk("t3_renable_hready", {31'd0, hready_out}, 32'd1);
        chk("t3_renable_hrdata", hrdata, 32'h1234_5678);
        tick();

        // 4. pipelined writes
        acc_cnt = 0;
        set_in(1, 1, 32'h8000_0000, 32'd0, 3'b001);
        tick();
        acc_cnt += int'(penable);
        set_in(1, 1, 32'h8000_0004, 32'h11, 3'b001);
        tick();
        acc_cnt += int'(penable);
        chk("t4_writep_paddr", paddr, 32'h8000_0000);
        chk("t4_writep_pwdata", pwdata, 32'h11);
        chk("t4_writep_hready", {31'd0, hready_out}, 32'd0);
        set_in(0, 1, 32'h8000_0004, 32'h22, 3'b001);
        tick();
        acc_cnt += int'(penable);
        chk("t4_wenablep_pen", {31'd0, penable}, 32'd1);
        set_in(0, 1, 32'd0, 32'd0, 3'b001);
        tick();
        acc_cnt += int'(penable);
        chk("t4_write_paddr", paddr, 32'h8000_0004);
        chk("t4_write_pwdata", pwdata, 32'h22);
        chk("t4_write_hready", {31'd0, hready_out}, 32'd1);
        set_in(0, 0, 32'd0, 32'd0, 3'b000);
        for (int i = 0; i < 3; i++) begin
            tick();
            acc_cnt += int'(penable);
        end
        chk("t4_apb_accesses", acc_cnt, 32'd2);

        // 5. write followed by read
        set_in(1, 1, 32'h8800_0000, 32'd0, 3'b001);
        tick();
        set_in(1, 0, 32'h8800_0008, 32'hDEAD_0005, 3'b001);
        tick();
        chk("t5_writep_paddr", paddr, 32'h8800_0000);
        set_in(1, 0, 32'h8800_0008, 32'd0, 3'b001);
        tick();
        set_in(0, 0, 32'd0, 32'd0, 3'b010);
        tick();
        chk("t5_read_paddr", paddr, 32'h8800_0008);
        chk("t5_read_pwrite", {31'd0, pwrite}, 32'd0);
        chk("t5_read_psel", {29'd0, pselx}, 32'd2);
        set_in(0, 0, 32'd0, 32'd0, 3'b000);
        tick();
        tick();

        // 6. back-to-back reads
        set_in(1, 0, 32'h8C00_0000, 32'd0, 3'b100);
        tick();
        chk("t6_pen0", {31'd0, penable}, 32'd0);
        chk("t6_psel0", {29'd0, pselx}, 32'd4);
        set_in(1, 0, 32'h8C00_0004, 32'd0, 3'b100);
        tick();
        chk("t6_pen1", {31'd0, penable}, 32'd1);
        tick();
        chk("t6_pen2", {31'd0, penable}, 32'd0);
        chk("t6_paddr2", paddr, 32'h8C00_0004);
        chk("t6_psel2", {29'd0, pselx}, 32'd4);
        set_in(0, 0, 32'd0, 32'd0, 3'b000);
        tick();
        chk("t6_pen3", {31'd0, penable}, 32'd1);
        chk("t6_psel3", {29'd0, pselx}, 32'd4);
        tick();

        // temp_sel = 0: a transfer that reaches no peripheral
        set_in(1, 0, 32'h8400_0040, 32'd0, 3'b000);
        tick();
        chk("nosel_psel", {29'd0, pselx}, 32'd0);
        chk("nosel_hready", {31'd0, hready_out}, 32'd0);
        chk("nosel_paddr", paddr, 32'h8400_0040);
        set_in(0, 0, 32'd0, 32'd0, 3'b000);
        tick();
        tick();

        // reset in the middle of a write's ENABLE cycle
        set_in(1, 1, 32'h9000_0000, 32'd0, 3'b001);
        tick();
        set_in(0, 1, 32'd0, 32'h77, 3'b001);
        tick();
        set_in(0, 0, 32'd0, 32'd0, 3'b000);
        tick();
        chk("mid_wenable_pen", {31'd0, penable}, 32'd1);
        hresetn = 1'b1;
        set_in(1, 1, 32'h9000_0004, 32'h88, 3'b001);
        tick();
        chk("mid_rst_psel", {29'd0, pselx}, 32'd0);
        chk("mid_rst_pen", {31'd0, penable}, 32'd0);
        chk("mid_rst_paddr", paddr, 32'd0);
        hresetn = 1'b0;
        set_in(0, 0, 32'd0, 32'd0, 3'b000);
        tick();
        tick();
        chk("post_rst_pen", {31'd0, penable}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/apb_controller.md
Name: apb_controller

Overview:
- Downstream of the AHB slave interface stage in the AHB-to-APB bridge.
- Consumes the slave stage's decoded, pipelined transfer information: valid, haddr_0/1, hwdata_0/1, hwrite_reg, temp_sel.
- Runs the APB SETUP/ENABLE protocol toward up to three peripherals.
- Drives hready_out back to the AHB side, stalling pipelined writes.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- NSEL, 3, number of peripheral selects; matches temp_sel width.

Ports:
- hclk  in  1  bridge clock; all state changes on rising edge.
- hresetn  in  1  synchronous, active-high reset.
- valid  in  1  current AHB cycle is a valid transfer.
- hwrite  in  1  direction of the current AHB address phase.
- hwrite_reg  in  1  hwrite delayed one cycle.
- haddr  in  ADDR_W  live AHB address.
- haddr_0  in  ADDR_W  haddr delayed 1 cycle.
- haddr_1  in  ADDR_W  haddr delayed 2 cycles.
- hwdata  in  DATA_W  live AHB write data.
- hwdata_0  in  DATA_W  hwdata delayed 1 cycle.
- hwdata_1  in  DATA_W  hwdata delayed 2 cycles; unused, reserved.
- temp_sel  in  NSEL  one-hot peripheral decode.
- prdata  in  DATA_W  APB read data.
- pselx  out  NSEL  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- hready_out  out  1  AHB ready.
- hrdata  out  DATA_W  AHB read data.

Behaviour:
- States: IDLE, WWAIT, WRITE, WRITEP, WENABLE, WENABLEP, READ, RENABLE. State register is 3 bits.
- Reset (hresetn=1 at a rising edge):
  - state=IDLE.
  - pselx=0, penable=0, pwrite=0, paddr=0, pwdata=0.
  - hready_out=1.
  - Reset overrides any in-flight transfer; a mid-transfer reset returns to IDLE in one cycle, with no further APB access.
- hrdata = prdata, combinational; not registered.
- Transitions:
  - IDLE: valid&hwrite -> WWAIT; valid&!hwrite -> READ; else IDLE.
  - WWAIT: valid -> WRITEP; else WRITE.
  - WRITE: valid -> WENABLEP; else WENABLE.
  - WRITEP: -> WENABLEP, unconditional.
  - WENABLEP: !hwrite_reg -> READ; valid&hwrite_reg -> WRITEP; !valid&hwrite_reg -> WRITE.
  - WENABLE and RENABLE: valid&!hwrite -> READ; valid&hwrite -> WWAIT; !valid -> IDLE.
  - READ: -> RENABLE, unconditional.
- All outputs are registered; they are computed from current state, next state and inputs, so they appear in the same cycle the target state is entered.
- Entering READ:
  - pselx=temp_sel, pwrite=0, penable=0, hready_out=0.
  - paddr=haddr when coming from IDLE/WENABLE/RENABLE.
  - paddr=haddr_1 when coming from WENABLEP (pending read).
- Entering WRITE or WRITEP:
  - pselx=temp_sel, pwrite=1, penable=0.
  - From WWAIT: paddr=haddr_0, pwdata=hwdata.
  - From WENABLEP: paddr=haddr_1, pwdata=hwdata_0.
  - hready_out=1 for WRITE, 0 for WRITEP.
- Entering RENABLE, WENABLE or WENABLEP:
  - penable=1, hready_out=1.
  - pselx, paddr, pwrite, pwdata held.
- Entering IDLE or WWAIT:
  - pselx=0, penable=0, hready_out=1.
  - paddr, pwdata, pwrite hold their last value.
- Protocol invariants:
  - Every APB access is exactly 2 cycles (SETUP, then ENABLE).
  - penable=1 only in the cycle directly after a SETUP with identical pselx, paddr and pwrite.
  - pselx is never asserted with more than one bit set.
  - No zero-wait APB; prdata is sampled by the AHB master in the RENABLE cycle.
- Boundary cases:
  - valid deasserting in WWAIT: a single write completes via WRITE -> WENABLE -> IDLE.
  - temp_sel=0 with valid=1: treated as a transfer, but pselx=0, so no peripheral responds.
  - Back-to-back reads are supported with no IDLE between them (RENABLE -> READ).

Test Plan:
1. Reset: hresetn=1 for 2 cycles with random inputs -> all outputs 0, hready_out=1, state IDLE; hresetn=1 asserted during WENABLE -> next cycle pselx=0, penable=0.
2. Single write: valid, hwrite=1, haddr=0x8000_0010, temp_sel=001; next cycle valid=0, hwdata=0xA5A5_0001 -> sequence WWAIT, WRITE (pselx=001, paddr=0x8000_0010, pwdata=0xA5A5_0001, penable=0), WENABLE (penable=1), IDLE.
3. Single read: valid, hwrite=0, haddr=0x8400_0020, temp_sel=010, prdata=0x1234_5678 -> READ (paddr=0x8400_0020, pwrite=0, hready_out=0), RENABLE (penable=1, hready_out=1, hrdata=0x1234_5678).
4. Pipelined writes: addresses 0x8000_0000 then 0x8000_0004 back to back, data 0x11, 0x22 -> WWAIT, WRITEP(0x8000_0000, 0x11, hready_out=0), WENABLEP, WRITE(0x8000_0004, 0x22), WENABLE; exactly two APB accesses.
5. Write followed by read: write to 0x8800_0000, then read of 0x8800_0008 on the next address phase -> WENABLEP exits to READ with paddr=0x8800_0008, pwrite=0.
6. Back-to-back reads: 0x8C00_0000 then 0x8C00_0004 with valid held -> READ, RENABLE, READ, RENABLE; penable toggles 0,1,0,1; pselx=100 throughout.
